m68k_rom_bus_ctl: RTL and testbench

68040 bus-cycle front end for the boot-ROM region. It decodes TS/TT/SIZ/RW, latches the address, and splits each transfer (single or 4-beat line burst) into longword read requests on a simple strobe/ack port. That port feeds the SPI flash reader stage. It drives TA/TEA/TBI and the data-buffer enable back to the CPU, and a watchdog terminates with TEA if the back end never answers.

---
 rtl/m68k_rom_bus_ctl.sv | 154 +++++++++++++++
 tb/tb_m68k_rom_bus_ctl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_rom_bus_ctl.sv
// 68040 boot-ROM bus-cycle front end: claims TS cycles in the ROM region and
// turns them into longword strobe/ack read requests, answering with TA/TEA/TBI.
module m68k_rom_bus_ctl #(
  parameter logic [3:0] BASE     = 4'h0,
  parameter int         TIMEOUT  = 1023,
  parameter bit         BURST_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic        ts,
  input  logic        tip,
  input  logic        rw,
  input  logic [1:0]  siz,
  input  logic [1:0]  tt,
  output logic        ta,
  output logic        tea,
  output logic        tbi,
  output logic        d_oe,
  output logic [31:0] d,
  output logic        rd_cyc,
  output logic        rd_stb,
  output logic [29:0] rd_addr,
  input  logic        rd_ack,
  input  logic        rd_err,
  input  logic [31:0] rd_data
);

  localparam logic [9:0] TIMEOUT_C = 10'(TIMEOUT);
  localparam logic [1:0] SIZ_LINE  = 2'b11;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, BEAT, ERR} state_t;

  state_t      state_r, state_nxt_s;
  logic        rw_r, rw_nxt_s;
  logic [1:0]  siz_r, siz_nxt_s;
  logic [1:0]  beat_r, beat_nxt_s;
  logic [9:0]  timer_r, timer_nxt_s;
  logic [31:0] d_r, d_nxt_s;
  logic [29:0] rd_addr_r, rd_addr_nxt_s;
  logic        ta_r, tea_r, tbi_r, d_oe_r, rd_cyc_r, rd_stb_r;
  logic        ta_s, tea_s, tbi_s, d_oe_s, rd_cyc_s, rd_stb_s;
  logic        claim_s, burst_s;
  logic        unused_ok_s;

  // tip and the byte-lane address bits carry no information for a longword ROM
  assign unused_ok_s = ^{tip, a[1:0]};

  assign claim_s = (ts == 1'b0) && (a[31:28] == BASE) && (tt == 2'b00);
  assign burst_s = rw_r && (siz_r == SIZ_LINE) && (BURST_EN == 1'b1);

  // Next-state, latch updates and the next value of every registered output
  always_comb begin
    state_nxt_s   = state_r;
    rw_nxt_s      = rw_r;
    siz_nxt_s     = siz_r;
    beat_nxt_s    = beat_r;
    timer_nxt_s   = timer_r;
    d_nxt_s       = d_r;
    rd_addr_nxt_s = rd_addr_r;
    case (state_r)
      IDLE: begin
        if (claim_s) begin
          rd_addr_nxt_s = a[31:2];
          rw_nxt_s      = rw;
          siz_nxt_s     = siz;
          beat_nxt_s    = 2'd0;
          state_nxt_s   = rw ? REQ : ERR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        timer_nxt_s = 10'd0;
        state_nxt_s = WAIT;
      end
      WAIT: begin
        if (rd_err) begin
          state_nxt_s = ERR;
        end else if (rd_ack) begin
          d_nxt_s     = rd_data;
          state_nxt_s = BEAT;
        end else if (timer_r == TIMEOUT_C) begin
          state_nxt_s = ERR;
        end else begin
          timer_nxt_s = timer_r + 10'd1;
        end
      end
      BEAT: begin
        // line bursts wrap inside the 16-byte line, upper address fixed
        if (burst_s && (beat_r != 2'd3)) begin
          rd_addr_nxt_s[1:0] = rd_addr_r[1:0] + 2'd1;
          beat_nxt_s         = beat_r + 2'd1;
          state_nxt_s        = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ERR:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase

    rd_stb_s = (state_nxt_s == REQ);
    rd_cyc_s = (state_nxt_s == REQ) || (state_nxt_s == WAIT) || (state_nxt_s == BEAT);
    ta_s     = (state_nxt_s != BEAT);
    d_oe_s   = (state_nxt_s != BEAT);
    tea_s    = (state_nxt_s != ERR);
    tbi_s    = !((state_nxt_s == BEAT) && rw_nxt_s && (siz_nxt_s == SIZ_LINE) &&
                 (BURST_EN == 1'b0));
  end

  // State, latched cycle attributes and registered bus outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      rw_r      <= 1'b0;
      siz_r     <= 2'b00;
      beat_r    <= 2'd0;
      timer_r   <= 10'd0;
      d_r       <= 32'd0;
      rd_addr_r <= 30'd0;
      ta_r      <= 1'b1;
      tea_r     <= 1'b1;
      tbi_r     <= 1'b1;
      d_oe_r    <= 1'b1;
      rd_cyc_r  <= 1'b0;
      rd_stb_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      rw_r      <= rw_nxt_s;
      siz_r     <= siz_nxt_s;
      beat_r    <= beat_nxt_s;
      timer_r   <= timer_nxt_s;
      d_r       <= d_nxt_s;
      rd_addr_r <= rd_addr_nxt_s;
      ta_r      <= ta_s;
      tea_r     <= tea_s;
      tbi_r     <= tbi_s;
      d_oe_r    <= d_oe_s;
      rd_cyc_r  <= rd_cyc_s;
      rd_stb_r  <= rd_stb_s;
    end
  end

  assign ta      = ta_r;
  assign tea     = tea_r;
  assign tbi     = tbi_r;
  assign d_oe    = d_oe_r;
  assign d       = d_r;
  assign rd_cyc  = rd_cyc_r;
  assign rd_stb  = rd_stb_r;
  assign rd_addr = rd_addr_r;

endmodule

// File: tb/tb_m68k_rom_bus_ctl.sv
// Directed bench for m68k_rom_bus_ctl: one burst-enabled and one burst-inhibited
// instance share the CPU and back-end stimulus; a monitor logs strobes and TA/TEA.
`timescale 1ns/1ps
module tb_m68k_rom_bus_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic        ts, tip, rw;
  logic [1:0]  siz, tt;
  logic        rd_ack, rd_err;
  logic [31:0] rd_data;

  logic        ta, tea, tbi, d_oe, rd_cyc, rd_stb;
  logic [31:0] d;
  logic [29:0] rd_addr;
  logic        n_ta, n_tea, n_tbi, n_d_oe, n_rd_cyc, n_rd_stb;
  logic [31:0] n_d;
  logic [29:0] n_rd_addr;

  always #5 clk = ~clk;

  m68k_rom_bus_ctl #(.BASE(4'h0), .TIMEOUT(15), .BURST_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .a(a), .ts(ts), .tip(tip), .rw(rw), .siz(siz), .tt(tt),
    .ta(ta), .tea(tea), .tbi(tbi), .d_oe(d_oe), .d(d), .rd_cyc(rd_cyc),
    .rd_stb(rd_stb), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_err(rd_err),
    .rd_data(rd_data));

  m68k_rom_bus_ctl #(.BASE(4'h0), .TIMEOUT(15), .BURST_EN(1'b0)) u_nob (
    .clk(clk), .rst(rst), .a(a), .ts(ts), .tip(tip), .rw(rw), .siz(siz), .tt(tt),
    .ta(n_ta), .tea(n_tea), .tbi(n_tbi), .d_oe(n_d_oe), .d(n_d), .rd_cyc(n_rd_cyc),
    .rd_stb(n_rd_stb), .rd_addr(n_rd_addr), .rd_ack(rd_ack), .rd_err(rd_err),
    .rd_data(rd_data));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // monitor state
  int cyc = 0;
  int t0 = 0;
  int stb_cnt, ta_cnt, tea_cnt, tbi_cnt, ta_cyc, tea_cyc;
  int both_cnt = 0;
  int n_stb_cnt, n_ta_cnt, n_tbi_ta_cnt;
  logic [31:0] n_d_cap;
  logic [29:0] addr_q[$];
  logic [31:0] d_q[$];

  // responder controls
  int ack_dly = 2;
  int resp_mode = 0;  // 0 ack, 1 never answer, 2 error on err_beat
  int err_beat = 0;
  int beat_i = 0;
  logic [31:0] data_base = 32'h0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rd_stb) begin stb_cnt++; addr_q.push_back(rd_addr); end
    if (!ta) begin
      if (ta_cnt == 0) ta_cyc = cyc;
      ta_cnt++;
      d_q.push_back(d);
    end
    if (!tea) begin
      if (tea_cnt == 0) tea_cyc = cyc;
      tea_cnt++;
    end
    if (!ta && !tea) both_cnt++;
    if (!tbi) tbi_cnt++;
    if (n_rd_stb) n_stb_cnt++;
    if (!n_ta) begin
      n_ta_cnt++;
      n_d_cap = n_d;
      if (!n_tbi) n_tbi_ta_cnt++;
    end
  end

  // back end: reacts to the burst-enabled instance's strobes
  initial begin
    rd_ack = 1'b0; rd_err = 1'b0; rd_data = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (rd_stb && resp_mode != 1) begin
        repeat (ack_dly) begin @(posedge clk); #1; end
        if (resp_mode == 2 && beat_i == err_beat) rd_err = 1'b1;
        else begin rd_ack = 1'b1; rd_data = data_base + 32'(beat_i); end
        beat_i++;
        @(posedge clk); #1;
        rd_ack = 1'b0; rd_err = 1'b0;
      end
    end
  end

  task automatic clr();
    stb_cnt = 0; ta_cnt = 0; tea_cnt = 0; tbi_cnt = 0; ta_cyc = -1; tea_cyc = -1;
    n_stb_cnt = 0; n_ta_cnt = 0; n_tbi_ta_cnt = 0; n_d_cap = 32'h0;
    addr_q.delete(); d_q.delete(); beat_i = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic [31:0] addr, input logic w_rw, input logic [1:0] w_siz,
                     input logic [1:0] w_tt);
    a = addr; rw = w_rw; siz = w_siz; tt = w_tt; ts = 1'b0; tip = 1'b0;
    t0 = cyc;
    @(posedge clk); #1;
    ts = 1'b1;
  endtask

  initial begin
    rst = 1'b0; ts = 1'b1; tip = 1'b1; a = 32'h0; rw = 1'b1; siz = 2'b00; tt = 2'b00;
    clr();
    idle(3);
    chk("rst_ta", {31'd0, ta}, 32'd1);
    chk("rst_tea", {31'd0, tea}, 32'd1);
    chk("rst_tbi_doe", {30'd0, tbi, d_oe}, 32'd3);
    chk("rst_stb_cyc", {30'd0, rd_stb, rd_cyc}, 32'd0);
    chk("rst_d", d, 32'h0);
    chk("rst_addr", {2'b00, rd_addr}, 32'h0);
    rst = 1'b1;
    idle(2);

    // long read, ack two cycles after strobe; a stray TS mid-cycle is ignored
    data_base = 32'hDEADBEEF; ack_dly = 2; resp_mode = 0; clr();
    cpu(32'h0000_1234, 1'b1, 2'b00, 2'b00);
    a = 32'h0000_0F00; rw = 1'b0; ts = 1'b0;
    @(posedge clk); #1;
    ts = 1'b1; rw = 1'b1;
    idle(20);
    chk("long_stb", stb_cnt, 1);
    chk("long_addr", {2'b00, addr_q[0]}, 32'h48D);
    chk("long_ta", ta_cnt, 1);
    chk("long_d", d_q[0], 32'hDEADBEEF);
    chk("long_lat", ta_cyc - t0, 4);
    chk("long_no_tea", tea_cnt, 0);
    chk("long_cyc_low", {31'd0, rd_cyc}, 32'd0);

    // minimum latency with ack on the first WAIT cycle
    data_base = 32'h1111_1111; ack_dly = 1; clr();
    cpu(32'h0000_0004, 1'b1, 2'b00, 2'b00);
    idle(10);
    chk("min_lat", ta_cyc - t0, 3);
    chk("min_d", d_q[0], 32'h1111_1111);

    // line read at 0x108 on both instances
    data_base = 32'hA000_0000; ack_dly = 1; clr();
    cpu(32'h0000_0108, 1'b1, 2'b11, 2'b00);
    idle(30);
    chk("burst_stb", stb_cnt, 4);
    chk("burst_a0", {2'b00, addr_q[0]}, 32'h42);
    chk("burst_a1", {2'b00, addr_q[1]}, 32'h43);
    chk("burst_a2", {2'b00, addr_q[2]}, 32'h40);
    chk("burst_a3", {2'b00, addr_q[3]}, 32'h41);
    chk("burst_ta", ta_cnt, 4);
    for (int i = 0; i < 4; i++) chk("burst_d", d_q[i], 32'hA000_0000 + 32'(i));
    chk("burst_tbi", tbi_cnt, 0);
    chk("burst_cyc_low", {31'd0, rd_cyc}, 32'd0);
    chk("nob_stb", n_stb_cnt, 1);
    chk("nob_ta", n_ta_cnt, 1);
    chk("nob_tbi_ta", n_tbi_ta_cnt, 1);
    chk("nob_d", n_d_cap, 32'hA000_0000);

    // write is refused with TEA one clock after TS
    clr();
    cpu(32'h0000_0000, 1'b0, 2'b00, 2'b00);
    rw = 1'b1;
    idle(5);
    chk("wr_stb", stb_cnt, 0);
    chk("wr_tea", tea_cnt, 1);
    chk("wr_tea_cyc", tea_cyc - t0, 1);
    chk("wr_ta", ta_cnt, 0);

    // outside the region or non-normal transfer type: no response
    clr();
    cpu(32'h1000_0000, 1'b1, 2'b00, 2'b00);
    idle(5);
    cpu(32'h0000_0000, 1'b1, 2'b00, 2'b11);
    idle(5);
    chk("unclaimed", stb_cnt + ta_cnt + tea_cnt + n_stb_cnt + n_ta_cnt, 0);

    // back end never answers
    resp_mode = 1; clr();
    cpu(32'h0000_0020, 1'b1, 2'b00, 2'b00);
    idle(30);
    chk("to_tea", tea_cnt, 1);
    chk("to_tea_cyc", tea_cyc - t0, 18);
    chk("to_ta", ta_cnt, 0);
    chk("to_cyc_low", {31'd0, rd_cyc}, 32'd0);

    // error on beat 2 of a burst abandons the rest
    resp_mode = 2; err_beat = 1; ack_dly = 1; clr();
    cpu(32'h0000_0108, 1'b1, 2'b11, 2'b00);
    idle(30);
    chk("err_stb", stb_cnt, 2);
    chk("err_ta", ta_cnt, 1);
    chk("err_tea", tea_cnt, 1);

    // reset during WAIT of beat 3
    resp_mode = 0; ack_dly = 2; data_base = 32'hC0DE_0000; clr();
    cpu(32'h0000_0108, 1'b1, 2'b11, 2'b00);
    for (int k = 0; k < 100 && stb_cnt < 3; k++) begin @(posedge clk); #1; end
    chk("rst_reach_b3", stb_cnt, 3);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_flags", {26'd0, ta, tea, tbi, d_oe, rd_cyc, rd_stb}, 32'h3C);
    chk("mid_rst_d", d, 32'h0);
    chk("mid_rst_addr", {2'b00, rd_addr}, 32'h0);
    rst = 1'b1;
    idle(5);
    data_base = 32'h5A5A_0000; clr();
    cpu(32'h0000_1234, 1'b1, 2'b00, 2'b00);
    idle(20);
    chk("post_rst_ta", ta_cnt, 1);
    chk("post_rst_d", d_q[0], 32'h5A5A_0000);
    chk("post_rst_addr", {2'b00, addr_q[0]}, 32'h48D);

    chk("ta_tea_excl", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
